axi_dbg_arb: RTL
================

# axi_dbg_arb

Two-port AXI4 arbiter that shares the SoC-side debug AXI master port between the JTAG debug module's AXI master (port 0) and a second requester (port 1, e.g. a boot loader or test DMA). It sits between the `AXI_BUS.Master` produced by the debug wrapper and the SoC interconnect slave port. Ownership is granted per session: one port owns all five channels until its outstanding transactions drain, so IDs pass through unmodified and responses never need reordering.

## Interface

- `AXI_ADDRESS_WIDTH`, 32: address width of all three buses.
- `AXI_DATA_WIDTH`, 64: data width.
- `AXI_ID_WIDTH`, 16: ID width; identical on all ports, no ID extension.
- `AXI_USER_WIDTH`, 10: user width.
- `MAX_OUTSTANDING`, 4: maximum in-flight reads, and separately writes, per session; range 1..15.
- `MAX_BURSTS`, 8: address handshakes the owner may issue after the other port starts requesting before it is forced to drain; range 1..255.

Ports:

- `clk_i` in 1: single clock for all logic and all buses.
- `rst_i` in 1: asynchronous, active-high reset.
- `slv0` `AXI_BUS.Slave` AXI: requester 0 (JTAG debug master).
- `slv1` `AXI_BUS.Slave` AXI: requester 1.
- `mst` `AXI_BUS.Master` AXI: shared downstream port.
- `owner_o` out 2: 2'b00 none, 2'b01 port 0, 2'b10 port 1; registered.

## Operation

- Request of port p: `slvp.aw_valid | slvp.ar_valid`.
- Counters `wr_cnt` and `rd_cnt`, each 4 bits.
  - `wr_cnt` increments on an `mst` AW handshake and decrements on a B handshake.
  - `rd_cnt` increments on an AR handshake and decrements on an R handshake with `r_last`.
  - An increment and a decrement in the same cycle leave the counter unchanged. AW and AR in the same cycle both count.
- `hold_cnt`, 8 bits: counts owner address handshakes (AW plus AR, so 0, 1 or 2 per cycle) while the non-owner requests. It is cleared on every entry to an OWN state.
- FSM states:
  - **IDLE**
    - Grants per arbitration policy (see Configuration) to the requesting port and moves to OWN0 or OWN1 on the next edge.
    - With no request, stays in IDLE.
  - **OWN0 / OWN1**
    - All owner channels are wired combinationally to `mst`. The non-owner sees readies and valids held at 0.
    - AW is blocked (forced `mst.aw_valid`=0, `slv.aw_ready`=0) when `wr_cnt`==`MAX_OUTSTANDING`. AR is blocked likewise on `rd_cnt`.
    - Goes to IDLE when both counters are 0 after the current cycle's updates and the owner shows no request.
    - Goes to DRAIN when `hold_cnt` reaches `MAX_BURSTS`.
    - If both exit conditions hold, IDLE wins.
  - **DRAIN**
    - Owner AW/AR blocked. W, B and R stay connected to the owner.
    - Goes to IDLE when both counters are 0.
- W is never arbitrated separately. Ownership is held until every B returns, so all W beats of the owner complete first.
- In IDLE, `mst.b_ready`=`mst.r_ready`=1. Stray responses left over from a reset are sunk and not counted; counters saturate at 0.

## Timing

- Reset values:
  - state IDLE, counters 0, round-robin pointer to port 0, `owner_o`=0.
  - All `mst` valids 0, all `slv*` readies and valids 0.
  - `mst` payload fields 0 while IDLE.
- Grant latency: a request seen in IDLE at cycle N is forwarded to `mst` at cycle N+1. Payload passes combinationally from then on.
- Ready/valid follow AXI rules. Once the arbiter forwards a valid it never withdraws it before the handshake.
- Leaving OWN, a pending but unforwarded owner valid stays pending at the owner. No handshake occurs.
- Release to IDLE to new grant costs one idle cycle on `mst`.
- `rst_i` asserted mid-transaction: everything returns to reset values immediately. Integrity of transactions in flight is not guaranteed.

## Configuration

- `AXI_DBG_ARB_FIXED_PRIO_EN` defined:
  - IDLE always grants port 0 when it requests.
  - `MAX_BURSTS` forced drain applies only when port 1 owns. Port 0 (debug) can never be preempted.
- Undefined:
  - Round-robin. The pointer moves to the other port on each grant, and on simultaneous requests the pointed port wins.
  - The forced drain applies to both owners.

## Test plan

- Port 0 single write to 0x1000 (id 0x3, 0xDEADBEEF) with port 1 idle: AW reaches `mst` at cycle 1 after request, B (id 0x3, OKAY) returns to port 0 only, then `owner_o` goes 01 to 00.
- Port 0 issues 6 back-to-back ARs with `MAX_OUTSTANDING`=4 and the slave delaying R: the 5th AR is held (`slv0.ar_ready`=0) until the first `r_last`, and `rd_cnt` never exceeds 4.
- Both ports request in the same IDLE cycle, round-robin build from reset: port 0 granted first, port 1 next. With the fixed-prio build, port 0 is granted both times if it re-requests.
- Port 1 streams reads and port 0 requests with `MAX_BURSTS`=8: after 8 port-1 ARs, state is DRAIN, port 1 gets no new AR, and port 0 is granted one cycle after `rd_cnt` reaches 0. In the fixed-prio build, port 0 streaming is never preempted.
- AW and AR handshakes in the same cycle as a B completion: `wr_cnt` unchanged, `rd_cnt` +1.
- `rst_i` pulsed with `wr_cnt`=2: all outputs reset asynchronously. Two late B responses are sunk in IDLE, and `wr_cnt` stays 0.

Source files
------------

// File: rtl/axi_dbg_arb_if.sv
// AXI4 bus bundle shared by the debug arbiter and its neighbours.
// Master drives requests and response readies; Slave is the mirror view.
interface AXI_BUS #(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 16,
   parameter int unsigned AXI_USER_WIDTH = 10
);
   logic [AXI_ID_WIDTH-1:0]     aw_id;
   logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]                  aw_len;
   logic [2:0]                  aw_size;
   logic [1:0]                  aw_burst;
   logic                        aw_lock;
   logic [3:0]                  aw_cache;
   logic [2:0]                  aw_prot;
   logic [3:0]                  aw_qos;
   logic [3:0]                  aw_region;
   logic [AXI_USER_WIDTH-1:0]   aw_user;
   logic                        aw_valid;
   logic                        aw_ready;

   logic [AXI_DATA_WIDTH-1:0]   w_data;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb;
   logic                        w_last;
   logic [AXI_USER_WIDTH-1:0]   w_user;
   logic                        w_valid;
   logic                        w_ready;

   logic [AXI_ID_WIDTH-1:0]     b_id;
   logic [1:0]                  b_resp;
   logic [AXI_USER_WIDTH-1:0]   b_user;
   logic                        b_valid;
   logic                        b_ready;

   logic [AXI_ID_WIDTH-1:0]     ar_id;
   logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]                  ar_len;
   logic [2:0]                  ar_size;
   logic [1:0]                  ar_burst;
   logic                        ar_lock;
   logic [3:0]                  ar_cache;
   logic [2:0]                  ar_prot;
   logic [3:0]                  ar_qos;
   logic [3:0]                  ar_region;
   logic [AXI_USER_WIDTH-1:0]   ar_user;
   logic                        ar_valid;
   logic                        ar_ready;

   logic [AXI_ID_WIDTH-1:0]     r_id;
   logic [AXI_DATA_WIDTH-1:0]   r_data;
   logic [1:0]                  r_resp;
   logic                        r_last;
   logic [AXI_USER_WIDTH-1:0]   r_user;
   logic                        r_valid;
   logic                        r_ready;

   modport Master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid, input aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
      input  b_id, b_resp, b_user, b_valid, output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid, input ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
   );

   modport Slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid, output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
      output b_id, b_resp, b_user, b_valid, input b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid, output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
   );
endinterface

// File: rtl/axi_dbg_arb.sv
// Session-based two-port AXI4 arbiter for the shared debug master port.
// Optional AXI_DBG_ARB_FIXED_PRIO_EN: port 0 always wins and is never preempted.
module axi_dbg_arb #(
   parameter int unsigned AXI_ADDRESS_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH    = 64,
   parameter int unsigned AXI_ID_WIDTH      = 16,
   parameter int unsigned AXI_USER_WIDTH    = 10,
   parameter int unsigned MAX_OUTSTANDING   = 4,
   parameter int unsigned MAX_BURSTS        = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   AXI_BUS.Slave      slv0,
   AXI_BUS.Slave      slv1,
   AXI_BUS.Master     mst,
   output logic [1:0] owner_o
);
   localparam logic [AXI_ADDRESS_WIDTH-1:0] ADDR0 = '0;
   localparam logic [AXI_DATA_WIDTH-1:0]    DATA0 = '0;
   localparam logic [AXI_ID_WIDTH-1:0]      ID0   = '0;
   localparam logic [AXI_USER_WIDTH-1:0]    USER0 = '0;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

   state_t     state;
   logic [3:0] wr_cnt, rd_cnt, wr_nxt, rd_nxt;
   logic [7:0] hold_cnt;
   logic [8:0] hold_sum;
   logic       aw_hold, ar_hold, aw_pend, ar_pend;
   logic       sel0, sel1, own_st, aw_en, ar_en;
   logic       req0, req1, own_req, oth_req, preempt, grant1;
   logic       aw_hs, ar_hs, b_hs, rl_hs;

   assign req0    = slv0.aw_valid | slv0.ar_valid;
   assign req1    = slv1.aw_valid | slv1.ar_valid;
   assign sel0    = (owner_o == 2'b01);
   assign sel1    = (owner_o == 2'b10);
   assign own_st  = (state == OWN0) || (state == OWN1);
   assign own_req = sel0 ? req0 : (sel1 & req1);
   assign oth_req = sel0 ? req1 : (sel1 & req0);

   // A valid already presented downstream stays forwarded until it handshakes,
   // even after the owner drops into DRAIN.
   assign aw_en = (own_st && (wr_cnt != 4'(MAX_OUTSTANDING))) || aw_hold;
   assign ar_en = (own_st && (rd_cnt != 4'(MAX_OUTSTANDING))) || ar_hold;

`ifdef AXI_DBG_ARB_FIXED_PRIO_EN
   assign preempt = (state == OWN1);
   assign grant1  = req1 & ~req0;
`else
   logic rr_ptr;
   assign preempt = 1'b1;
   assign grant1  = req1 & (~req0 | rr_ptr);
`endif

   // AW channel
   assign mst.aw_valid  = aw_en & (sel0 ? slv0.aw_valid : (sel1 & slv1.aw_valid));
   assign slv0.aw_ready = aw_en & sel0 & mst.aw_ready;
   assign slv1.aw_ready = aw_en & sel1 & mst.aw_ready;
   assign mst.aw_id     = sel0 ? slv0.aw_id     : sel1 ? slv1.aw_id     : ID0;
   assign mst.aw_addr   = sel0 ? slv0.aw_addr   : sel1 ? slv1.aw_addr   : ADDR0;
   assign mst.aw_len    = sel0 ? slv0.aw_len    : sel1 ? slv1.aw_len    : 8'd0;
   assign mst.aw_size   = sel0 ? slv0.aw_size   : sel1 ? slv1.aw_size   : 3'd0;
   assign mst.aw_burst  = sel0 ? slv0.aw_burst  : sel1 ? slv1.aw_burst  : 2'd0;
   assign mst.aw_lock   = sel0 ? slv0.aw_lock   : (sel1 & slv1.aw_lock);
   assign mst.aw_cache  = sel0 ? slv0.aw_cache  : sel1 ? slv1.aw_cache  : 4'd0;
   assign mst.aw_prot   = sel0 ? slv0.aw_prot   : sel1 ? slv1.aw_prot   : 3'd0;
   assign mst.aw_qos    = sel0 ? slv0.aw_qos    : sel1 ? slv1.aw_qos    : 4'd0;
   assign mst.aw_region = sel0 ? slv0.aw_region : sel1 ? slv1.aw_region : 4'd0;
   assign mst.aw_user   = sel0 ? slv0.aw_user   : sel1 ? slv1.aw_user   : USER0;

   // W channel follows the owner for the whole session
   assign mst.w_valid   = sel0 ? slv0.w_valid : (sel1 & slv1.w_valid);
   assign slv0.w_ready  = sel0 & mst.w_ready;
   assign slv1.w_ready  = sel1 & mst.w_ready;
   assign mst.w_data    = sel0 ? slv0.w_data : sel1 ? slv1.w_data : DATA0;
   assign mst.w_strb    = sel0 ? slv0.w_strb : sel1 ? slv1.w_strb : '0;
   assign mst.w_last    = sel0 ? slv0.w_last : (sel1 & slv1.w_last);
   assign mst.w_user    = sel0 ? slv0.w_user : sel1 ? slv1.w_user : USER0;

   // B channel: sink everything while IDLE
   assign mst.b_ready   = (state == IDLE) | (sel0 & slv0.b_ready) | (sel1 & slv1.b_ready);
   assign slv0.b_valid  = sel0 & mst.b_valid;
   assign slv1.b_valid  = sel1 & mst.b_valid;
   assign slv0.b_id     = mst.b_id;
   assign slv1.b_id     = mst.b_id;
   assign slv0.b_resp   = mst.b_resp;
   assign slv1.b_resp   = mst.b_resp;
   assign slv0.b_user   = mst.b_user;
   assign slv1.b_user   = mst.b_user;

   // AR channel
   assign mst.ar_valid  = ar_en & (sel0 ? slv0.ar_valid : (sel1 & slv1.ar_valid));
   assign slv0.ar_ready = ar_en & sel0 & mst.ar_ready;
   assign slv1.ar_ready = ar_en & sel1 & mst.ar_ready;
   assign mst.ar_id     = sel0 ? slv0.ar_id     : sel1 ? slv1.ar_id     : ID0;
   assign mst.ar_addr   = sel0 ? slv0.ar_addr   : sel1 ? slv1.ar_addr   : ADDR0;
   assign mst.ar_len    = sel0 ? slv0.ar_len    : sel1 ? slv1.ar_len    : 8'd0;
   assign mst.ar_size   = sel0 ? slv0.ar_size   : sel1 ? slv1.ar_size   : 3'd0;
   assign mst.ar_burst  = sel0 ? slv0.ar_burst  : sel1 ? slv1.ar_burst  : 2'd0;
   assign mst.ar_lock   = sel0 ? slv0.ar_lock   : (sel1 & slv1.ar_lock);
   assign mst.ar_cache  = sel0 ? slv0.ar_cache  : sel1 ? slv1.ar_cache  : 4'd0;
   assign mst.ar_prot   = sel0 ? slv0.ar_prot   : sel1 ? slv1.ar_prot   : 3'd0;
   assign mst.ar_qos    = sel0 ? slv0.ar_qos    : sel1 ? slv1.ar_qos    : 4'd0;
   assign mst.ar_region = sel0 ? slv0.ar_region : sel1 ? slv1.ar_region : 4'd0;
   assign mst.ar_user   = sel0 ? slv0.ar_user   : sel1 ? slv1.ar_user   : USER0;

   // R channel
   assign mst.r_ready   = (state == IDLE) | (sel0 & slv0.r_ready) | (sel1 & slv1.r_ready);
   assign slv0.r_valid  = sel0 & mst.r_valid;
   assign slv1.r_valid  = sel1 & mst.r_valid;
   assign slv0.r_id     = mst.r_id;
   assign slv1.r_id     = mst.r_id;
   assign slv0.r_data   = mst.r_data;
   assign slv1.r_data   = mst.r_data;
   assign slv0.r_resp   = mst.r_resp;
   assign slv1.r_resp   = mst.r_resp;
   assign slv0.r_last   = mst.r_last;
   assign slv1.r_last   = mst.r_last;
   assign slv0.r_user   = mst.r_user;
   assign slv1.r_user   = mst.r_user;

   assign aw_hs   = mst.aw_valid & mst.aw_ready;
   assign ar_hs   = mst.ar_valid & mst.ar_ready;
   assign b_hs    = mst.b_valid & mst.b_ready;
   assign rl_hs   = mst.r_valid & mst.r_ready & mst.r_last;
   assign aw_pend = mst.aw_valid & ~mst.aw_ready;
   assign ar_pend = mst.ar_valid & ~mst.ar_ready;

   // Decrements saturate at 0 so stray post-reset responses are ignored
   always_comb begin
      wr_nxt = wr_cnt;
      rd_nxt = rd_cnt;
      if (aw_hs && !b_hs)                         wr_nxt = wr_cnt + 4'd1;
      else if (b_hs && !aw_hs && wr_cnt != 4'd0)  wr_nxt = wr_cnt - 4'd1;
      if (ar_hs && !rl_hs)                        rd_nxt = rd_cnt + 4'd1;
      else if (rl_hs && !ar_hs && rd_cnt != 4'd0) rd_nxt = rd_cnt - 4'd1;
   end

   assign hold_sum = {1'b0, hold_cnt} + 9'(aw_hs) + 9'(ar_hs);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         owner_o  <= 2'b00;
         wr_cnt   <= 4'd0;
         rd_cnt   <= 4'd0;
         hold_cnt <= 8'd0;
         aw_hold  <= 1'b0;
         ar_hold  <= 1'b0;
`ifndef AXI_DBG_ARB_FIXED_PRIO_EN
         rr_ptr   <= 1'b0;
`endif
      end else begin
         wr_cnt  <= wr_nxt;
         rd_cnt  <= rd_nxt;
         aw_hold <= aw_pend;
         ar_hold <= ar_pend;
         case (state)
            IDLE: begin
               hold_cnt <= 8'd0;
               if (req0 | req1) begin
                  state   <= grant1 ? OWN1 : OWN0;
                  owner_o <= grant1 ? 2'b10 : 2'b01;
`ifndef AXI_DBG_ARB_FIXED_PRIO_EN
                  rr_ptr  <= ~grant1;
`endif
               end
            end
            OWN0, OWN1: begin
               if (oth_req && preempt) hold_cnt <= hold_sum[7:0];
               if (wr_nxt == 4'd0 && rd_nxt == 4'd0 && !own_req) begin
                  state   <= IDLE;
                  owner_o <= 2'b00;
               end else if (preempt && oth_req && hold_sum >= 9'(MAX_BURSTS)) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (wr_nxt == 4'd0 && rd_nxt == 4'd0 && !aw_pend && !ar_pend) begin
                  state   <= IDLE;
                  owner_o <= 2'b00;
               end
            end
         endcase
      end
   end
endmodule
